// File: rtl/dff_resp_checker_pkg.sv
// Shared types, constants and helpers for the flop response checkers.
package dff_resp_checker_pkg;

    // Widest counter the helpers below support.
    localparam int unsigned CNT_W_MAX = 32;

    // All-ones "no error seen" index; truncate to the counter width at use.
    localparam logic [CNT_W_MAX-1:0] NO_ERR_IDX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic logic [CNT_W_MAX-1:0] sat_inc(
        input logic [CNT_W_MAX-1:0] val,
        input int unsigned          width
    );
        logic [CNT_W_MAX:0] lim;
        lim = ((CNT_W_MAX+1)'(1) << width) - (CNT_W_MAX+1)'(1);
        if ({1'b0, val} >= lim) begin
            return val;
        end
        return val + CNT_W_MAX'(1);
    endfunction

endpackage

// File: rtl/dff_resp_checker_golden.sv
// Registered reference flop: clear beats set, set beats data.
module dff_golden_model (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    input  logic set,
    input  logic clr,
    output logic exp_q
);

    // Track what a correct flop would present one cycle after the stimulus.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= 1'b0;
        end else if (en) begin
            exp_q <= clr ? 1'b0 : (set ? 1'b1 : d);
        end
    end

endmodule

// File: rtl/dff_resp_checker.sv
// Capture-side checker for a flop under test: runs a bounded compare window
// against the golden model and reports error count, first failing index and
// pass/fail. CNT_W must not exceed 32.
module dff_resp_checker
    import dff_resp_checker_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WARMUP_CYC = 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_checks,
    input  logic             dut_d,
    input  logic             dut_set,
    input  logic             dut_rst,
    input  logic             dut_q,
    input  logic             dut_nq,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             err_seen
);

    localparam int unsigned WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0]  NO_ERR    = CNT_W'(NO_ERR_IDX);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   run_len_q, run_len_d;
    logic [CNT_W-1:0]   check_idx_q, check_idx_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   first_err_q, first_err_d;
    logic               err_seen_q, err_seen_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               mismatch_c;
    logic               model_en;
    logic               exp_q;

    // Model only advances while a run is active so idle X never reaches it.
    assign model_en = (state_q == WARMUP) || (state_q == CHECK);

    dff_golden_model u_model (
        .clk   (clk),
        .rst   (Reset),
        .en    (model_en),
        .d     (dut_d),
        .set   (dut_set),
        .clr   (dut_rst),
        .exp_q (exp_q)
    );

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        check_idx_d = check_idx_q;
        warm_cnt_d  = warm_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        mismatch_c  = 1'b0;

        if (abort) begin
            // Results stay readable after an abort; only the state drops.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d     = WARMUP;
                        run_len_d   = num_checks;
                        check_idx_d = '0;
                        warm_cnt_d  = '0;
                        err_cnt_d   = '0;
                        err_seen_d  = 1'b0;
                        first_err_d = NO_ERR;
                    end
                end
                WARMUP: begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = (run_len_q == '0) ? DONE : CHECK;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WARM_W'(1);
                    end
                end
                CHECK: begin
                    mismatch_c = (dut_q != exp_q) || (dut_nq != ~dut_q);
                    if (mismatch_c) begin
                        err_cnt_d  = CNT_W'(sat_inc(CNT_W_MAX'(err_cnt_q), CNT_W));
                        err_seen_d = 1'b1;
                        if (!err_seen_q) begin
                            first_err_d = check_idx_q;
                        end
                    end
                    if (check_idx_q == run_len_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        check_idx_d = check_idx_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == WARMUP) || (state_d == CHECK);
        done_d = (state_d == DONE) && (state_q != DONE);
        pass_d = (state_d == DONE) && !err_seen_d;
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            run_len_q   <= '0;
            check_idx_q <= '0;
            warm_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= NO_ERR;
            err_seen_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            check_idx_q <= check_idx_d;
            warm_cnt_q  <= warm_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
    assign err_seen      = err_seen_q;

endmodule
